// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default weight width, the weight-loader state encoding
// and a width helper.
package cnn_pkg;

   localparam int CNN_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } loader_state_e;

   // Counter width for a range of 'value' states, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/weight_shadow_bank.sv
// Double-buffered weight storage: a shadow bank written one word at a time and an
// active bank that is replaced from the shadow bank as a whole on a copy strobe.
module weight_shadow_bank
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int DEPTH      = 150,
   parameter int AW         = clog2_min1(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        copy,
   output logic [DEPTH*DATA_WIDTH-1:0] active
);

   logic [DEPTH*DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [DEPTH*DATA_WIDTH-1:0] active_q, active_d;

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_en) begin
         shadow_d[wr_addr*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end
      if (copy) begin
         active_d = shadow_q;
      end
   end

   // NOTE: both banks are reset so a reset in the middle of a load leaves the layer on all-zero weights.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active = active_q;

endmodule

// File: rtl/conv_weight_loader.sv
// Streams filter weights into a shadow bank over valid/ready and swaps the completed
// load into the active filter bus that feeds the conv layer.
module conv_weight_loader
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int KERNEL     = 5,
   parameter int IN_CH      = 1,
   parameter int OUT_CH     = 6,
   parameter int MSB_FIRST  = 1,
   parameter int AUTO_SWAP  = 0
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          load_start,
   input  logic                                          s_valid,
   input  logic [DATA_WIDTH-1:0]                         s_data,
   input  logic                                          s_last,
   output logic                                          s_ready,
   input  logic                                          swap,
   output logic [KERNEL*KERNEL*IN_CH*OUT_CH*DATA_WIDTH-1:0] filters,
   output logic                                          weights_valid,
   output logic                                          load_done,
   output logic                                          length_err
);

   localparam int WPF   = KERNEL * KERNEL * IN_CH;
   localparam int TOTAL = WPF * OUT_CH;
   localparam int WW    = clog2_min1(WPF);
   localparam int FCW   = clog2_min1(OUT_CH);
   localparam int AW    = clog2_min1(TOTAL);
   localparam logic [WW-1:0]  WORD_MAX = WW'(WPF - 1);
   localparam logic [FCW-1:0] FILT_MAX = FCW'(OUT_CH - 1);

   loader_state_e  state_q, state_d;
   logic [WW-1:0]  word_q, word_d;
   logic [FCW-1:0] filt_q, filt_d;
   logic           load_done_q, load_done_d;
   logic           length_err_q, length_err_d;
   logic           weights_valid_q, weights_valid_d;

   logic           accept;
   logic           last_slot;
   logic           swap_fire;
   int unsigned    slot_int;
   logic [AW-1:0]  slot_addr;

   // A word that arrives together with load_start belongs to the abandoned load.
   assign accept    = s_valid && (state_q == ST_LOAD) && !load_start;
   assign last_slot = (word_q == WORD_MAX) && (filt_q == FILT_MAX);
   assign swap_fire = (state_q == ST_FULL) && ((AUTO_SWAP != 0) || swap);

   always_comb begin
      slot_int  = int'(filt_q) * WPF;
      slot_int  = slot_int + ((MSB_FIRST != 0) ? (WPF - 1 - int'(word_q)) : int'(word_q));
      slot_addr = AW'(slot_int);
   end

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         word_q          <= '0;
         filt_q          <= '0;
         load_done_q     <= 1'b0;
         length_err_q    <= 1'b0;
         weights_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         word_q          <= word_d;
         filt_q          <= filt_d;
         load_done_q     <= load_done_d;
         length_err_q    <= length_err_d;
         weights_valid_q <= weights_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_LOAD: begin
            if (accept && last_slot)   state_d = ST_FULL;
            else if (accept && s_last) state_d = ST_IDLE;
         end
         ST_FULL: if (swap_fire) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A swap in the same cycle still completes in the bank; the new load then begins.
      if (load_start) state_d = ST_LOAD;
   end

   always_comb begin
      word_d = word_q;
      filt_d = filt_q;
      if (load_start || (accept && (last_slot || s_last))) begin
         word_d = '0;
         filt_d = '0;
      end else if (accept) begin
         if (word_q == WORD_MAX) begin
            word_d = '0;
            filt_d = filt_q + 1'b1;
         end else begin
            word_d = word_q + 1'b1;
         end
      end
   end

   always_comb begin
      s_ready         = (state_q == ST_LOAD);
      load_done_d     = accept && last_slot;
      length_err_d    = accept && (s_last != last_slot);
      weights_valid_d = weights_valid_q || swap_fire;
   end

   weight_shadow_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (TOTAL),
      .AW         (AW)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept),
      .wr_addr (slot_addr),
      .wr_data (s_data),
      .copy    (swap_fire),
      .active  (filters)
   );

   assign weights_valid = weights_valid_q;
   assign load_done     = load_done_q;
   assign length_err    = length_err_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a word-list reference model.
module tb_conv_weight_loader;

   localparam int DW    = 16;
   localparam int WPF   = 4;
   localparam int TOTAL = 8;
   localparam int FB    = TOTAL * DW;

   logic          clk = 1'b0;
   logic          reset, load_start, s_valid, s_last, swap;
   logic [DW-1:0] s_data;
   logic          rdy_m, rdy_l, wv_m, wv_l, done_m, done_l, err_m, err_l;
   logic [FB-1:0] filt_m, filt_l;

   always #5 clk = ~clk;

   conv_weight_loader #(
      .DATA_WIDTH (DW), .KERNEL (2), .IN_CH (1), .OUT_CH (2), .MSB_FIRST (1), .AUTO_SWAP (0)
   ) dut_msb (
      .clk (clk), .reset (reset), .load_start (load_start), .s_valid (s_valid),
      .s_data (s_data), .s_last (s_last), .s_ready (rdy_m), .swap (swap),
      .filters (filt_m), .weights_valid (wv_m), .load_done (done_m), .length_err (err_m)
   );

   conv_weight_loader #(
      .DATA_WIDTH (DW), .KERNEL (2), .IN_CH (1), .OUT_CH (2), .MSB_FIRST (0), .AUTO_SWAP (0)
   ) dut_lsb (
      .clk (clk), .reset (reset), .load_start (load_start), .s_valid (s_valid),
      .s_data (s_data), .s_last (s_last), .s_ready (rdy_l), .swap (swap),
      .filters (filt_l), .weights_valid (wv_l), .load_done (done_l), .length_err (err_l)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: words are placed by their stream index n, filter n/WPF, word n%WPF.
   bit            m_loading, m_full, m_wv, m_done, m_err, m_acc, m_swp;
   int            m_n;
   logic [DW-1:0] sh_m [TOTAL];
   logic [DW-1:0] sh_l [TOTAL];
   logic [DW-1:0] act_m [TOTAL];
   logic [DW-1:0] act_l [TOTAL];

   function automatic logic [FB-1:0] pack(input logic [DW-1:0] a [TOTAL]);
      logic [FB-1:0] v;
      for (int s = 0; s < TOTAL; s++) v[s*DW +: DW] = a[s];
      return v;
   endfunction

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_loading = 0; m_full = 0; m_wv = 0; m_done = 0; m_err = 0; m_n = 0;
         for (int s = 0; s < TOTAL; s++) begin
            sh_m[s] = '0; sh_l[s] = '0; act_m[s] = '0; act_l[s] = '0;
         end
      end else begin
         m_acc  = s_valid && m_loading && !load_start;
         m_swp  = m_full && swap;
         m_done = 0;
         m_err  = 0;
         if (m_swp) begin
            act_m  = sh_m;
            act_l  = sh_l;
            m_full = 0;
            m_wv   = 1;
         end
         if (m_acc) begin
            sh_m[(m_n / WPF) * WPF + (WPF - 1 - (m_n % WPF))] = s_data;
            sh_l[m_n] = s_data;
            if (m_n == TOTAL - 1) begin
               m_full = 1; m_loading = 0; m_done = 1; m_err = !s_last; m_n = 0;
            end else if (s_last) begin
               m_loading = 0; m_err = 1; m_n = 0;
            end else begin
               m_n++;
            end
         end
         if (load_start) begin
            m_loading = 1; m_full = 0; m_n = 0;
         end
      end
   end

   // Per-cycle comparison on the falling edge, away from the active edge.
   initial forever begin
      @(negedge clk);
      check("s_ready_msb", FB'(rdy_m), FB'(m_loading));
      check("s_ready_lsb", FB'(rdy_l), FB'(m_loading));
      check("weights_valid_msb", FB'(wv_m), FB'(m_wv));
      check("weights_valid_lsb", FB'(wv_l), FB'(m_wv));
      check("load_done_msb", FB'(done_m), FB'(m_done));
      check("load_done_lsb", FB'(done_l), FB'(m_done));
      check("length_err_msb", FB'(err_m), FB'(m_err));
      check("length_err_lsb", FB'(err_l), FB'(m_err));
      check("filters_msb", filt_m, pack(act_m));
      check("filters_lsb", filt_l, pack(act_l));
      if (done_m === 1'b1) done_cnt++;
      if (err_m === 1'b1) err_cnt++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic pulse_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
   endtask

   // Offers one word and holds it until the registered s_ready lets it transfer.
   task automatic send(input logic [DW-1:0] d, input bit last, input bit gaps);
      int guard = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) tick();
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!rdy_m && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: s_ready stayed %b for word %h, required 1", rdy_m, d);
      end
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic load8(input logic [DW-1:0] base, input logic [DW-1:0] step, input bit gaps);
      for (int i = 0; i < TOTAL; i++) send(DW'(base + step * DW'(i)), i == TOTAL - 1, gaps);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded the bound", $time);
      $fatal(1);
   end

   initial begin
      int d0, e0;
      reset = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; swap = 1'b0; s_data = '0;
      tick(3);
      reset = 1'b0;
      tick();
      check("reset_filters", filt_m, '0);
      check("reset_s_ready", FB'(rdy_m), '0);
      check("reset_weights_valid", FB'(wv_m), '0);

      // Gap-free load of 1..8, then swap.
      d0 = done_cnt; e0 = err_cnt;
      pulse_start();
      load8(16'h0001, 16'h0001, 0);
      tick();
      pulse_swap();
      check("a_filters_msb", filt_m, 128'h0005_0006_0007_0008_0001_0002_0003_0004);
      check("a_filters_lsb", filt_l, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      check("a_model_msb", pack(act_m), 128'h0005_0006_0007_0008_0001_0002_0003_0004);
      check("a_weights_valid", FB'(wv_m), FB'(1));
      check("a_load_done_pulses", FB'(done_cnt - d0), FB'(1));
      check("a_length_err_pulses", FB'(err_cnt - e0), FB'(0));

      // Same mapping with random valid gaps.
      pulse_start();
      load8(16'h1111, 16'h1111, 1);
      tick(2);
      check("b_s_ready_full", FB'(rdy_m), '0);
      pulse_swap();
      check("b_filters_msb", filt_m, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
      check("b_filters_lsb", filt_l, 128'h8888_7777_6666_5555_4444_3333_2222_1111);

      // Early s_last on the 5th word: error, back to idle, swap ignored.
      e0 = err_cnt;
      pulse_start();
      for (int i = 0; i < 5; i++) send(DW'(16'hB001 + i), i == 4, 0);
      tick();
      check("c_length_err_pulses", FB'(err_cnt - e0), FB'(1));
      check("c_s_ready_idle", FB'(rdy_m), '0);
      pulse_swap();
      tick();
      check("c_filters_kept", filt_m, 128'h5555_6666_7777_8888_1111_2222_3333_4444);

      // Second load does not disturb the active bank until the swap edge.
      pulse_start();
      load8(16'hA001, 16'h0001, 0);
      tick(3);
      check("d_filters_before_swap", filt_m, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
      pulse_swap();
      check("d_filters_after_swap", filt_m, 128'hA005_A006_A007_A008_A001_A002_A003_A004);

      // Restart after 3 words; the word offered with load_start is discarded.
      pulse_start();
      for (int i = 0; i < 3; i++) send(DW'(16'hE001 + i), 0, 0);
      load_start = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
      tick();
      load_start = 1'b0; s_valid = 1'b0;
      load8(16'hC001, 16'h0001, 0);
      pulse_swap();
      check("e_filters_fresh", filt_m, 128'hC005_C006_C007_C008_C001_C002_C003_C004);

      // load_start together with swap in FULL: swap lands, new load begins.
      pulse_start();
      load8(16'h7001, 16'h0001, 0);
      load_start = 1'b1; swap = 1'b1;
      tick();
      load_start = 1'b0; swap = 1'b0;
      check("g_filters_swapped", filt_m, 128'h7005_7006_7007_7008_7001_7002_7003_7004);
      check("g_s_ready_load", FB'(rdy_m), FB'(1));
      load8(16'h9001, 16'h0001, 0);
      pulse_swap();
      check("g_filters_second", filt_m, 128'h9005_9006_9007_9008_9001_9002_9003_9004);

      // Random loads with random gaps, early/missing s_last and optional swaps.
      for (int it = 0; it < 16; it++) begin
         pulse_start();
         for (int n = 0; n < TOTAL; n++) begin
            bit last;
            last = (n == TOTAL - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            send(DW'($urandom), last, 1);
            if (last && n < TOTAL - 1) break;
         end
         tick($urandom_range(0, 2));
         if ($urandom_range(0, 3) != 0) pulse_swap();
         tick();
      end

      // Reset in the middle of a load clears everything.
      pulse_start();
      for (int i = 0; i < 3; i++) send(DW'(16'h3001 + i), 0, 0);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      check("i_filters_msb_zero", filt_m, '0);
      check("i_filters_lsb_zero", filt_l, '0);
      check("i_weights_valid_zero", FB'(wv_m), '0);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
